crc_frame_rx: RTL

- Receive-side frame checker between the UART receiver and the control logic of the Avalon-MM UART peripheral.
- Consumes the byte/done pulses produced by the UART receiver and groups them into fixed-length frames of FRAME_LEN payload bytes followed by one CRC-8 byte.
- Computes CRC-8 with key CRC_KEY bit-serially and buffers the payload.
- Releases the payload on a valid/ready byte stream only when the CRC matches; otherwise the frame is discarded.

---
 rtl/crc_frame_rx.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/crc_frame_rx.sv
// crc_frame_rx: receive-side frame checker between the UART receiver and the
// control logic of the Avalon-MM UART peripheral. Bytes are grouped into frames
// of FRAME_LEN payload bytes plus one CRC-8 byte. The CRC is computed bit-serially
// (MSB first, init 0, no reflection, no final XOR). The payload is released on a
// valid/ready stream only when the received CRC matches.
// Optional feature: define CRC_FRAME_TIMEOUT_EN to abort partial frames after
// TIMEOUT_CYCLES idle cycles between bytes.
module crc_frame_rx #(
  parameter int         FRAME_LEN      = 4,
  parameter logic [7:0] CRC_KEY        = 8'h37,
  parameter int         TIMEOUT_CYCLES = 57288
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       busy,
  output logic [2:0] status,
  input  logic       clr_status
);

  localparam int              IW     = $clog2(FRAME_LEN);
  localparam logic [IW:0]     LEN_C  = (IW+1)'(FRAME_LEN);
  localparam logic [IW-1:0]   LAST_K = IW'(FRAME_LEN - 1);

  // Reject parameter values the counters and buffer cannot represent
  if (FRAME_LEN < 2 || FRAME_LEN > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 131071) begin : g_param_check
    $error("crc_frame_rx: FRAME_LEN must be 2..16 and TIMEOUT_CYCLES 1..131071");
  end

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    COLLECT,
    WAIT_CRC,
    CHECK,
    DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    pay_q [FRAME_LEN];
  logic [7:0]    pay_d [FRAME_LEN];
  logic [IW:0]   idx_q, idx_d;
  logic [IW-1:0] k_q, k_d;
  logic [7:0]    crc_q, crc_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    rx_crc_q, rx_crc_d;
  logic          out_valid_q, out_valid_d;
  logic          frame_ok_q, frame_ok_d;
  logic          frame_err_q, frame_err_d;
  logic [2:0]    status_q, status_d;
  logic          set_crc_err, set_overrun, set_timeout;
  logic          timeout_hit;

`ifdef CRC_FRAME_TIMEOUT_EN
  localparam logic [16:0] TIMEOUT_C = 17'(TIMEOUT_CYCLES);

  logic [16:0] timer_q, timer_d;

  // Idle-gap counter: restarts on every received byte, runs only while waiting for one
  always_comb begin
    timer_d = '0;
    if (!rx_done && !timeout_hit && (state_q == COLLECT || state_q == WAIT_CRC)) begin
      timer_d = timer_q + 17'd1;
    end
  end

  assign timeout_hit = (state_q == COLLECT || state_q == WAIT_CRC) && (timer_q == TIMEOUT_C);

  // Idle-gap counter register
  always_ff @(posedge clock) begin
    if (!resetn) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Frame sequencing, CRC shifting, payload buffering and drain handshake
  always_comb begin
    state_d     = state_q;
    pay_d       = pay_q;
    idx_d       = idx_q;
    k_d         = k_q;
    crc_d       = crc_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    rx_crc_d    = rx_crc_q;
    out_valid_d = 1'b0;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    set_crc_err = 1'b0;
    set_overrun = 1'b0;
    set_timeout = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_done) begin
          pay_d[0]  = rx_data;
          shreg_d   = rx_data;
          idx_d     = (IW+1)'(1);
          bit_cnt_d = 3'd0;
          state_d   = CALC;
        end
      end

      CALC: begin
        crc_d     = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ shreg_q[7]) ? CRC_KEY : 8'h00);
        shreg_d   = {shreg_q[6:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (rx_done) begin
          set_overrun = 1'b1;
        end
        if (bit_cnt_q == 3'd7) begin
          state_d = (idx_q == LEN_C) ? WAIT_CRC : COLLECT;
        end
      end

      COLLECT: begin
        if (timeout_hit) begin
          frame_err_d = 1'b1;
          set_timeout = 1'b1;
          set_overrun = rx_done;
          crc_d       = 8'h00;
          state_d     = IDLE;
        end else if (rx_done) begin
          pay_d[idx_q[IW-1:0]] = rx_data;
          shreg_d   = rx_data;
          idx_d     = idx_q + (IW+1)'(1);
          bit_cnt_d = 3'd0;
          state_d   = CALC;
        end
      end

      WAIT_CRC: begin
        if (timeout_hit) begin
          frame_err_d = 1'b1;
          set_timeout = 1'b1;
          set_overrun = rx_done;
          crc_d       = 8'h00;
          state_d     = IDLE;
        end else if (rx_done) begin
          rx_crc_d = rx_data;
          state_d  = CHECK;
        end
      end

      CHECK: begin
        crc_d = 8'h00;
        if (rx_done) begin
          set_overrun = 1'b1;
        end
        if (rx_crc_q == crc_q) begin
          frame_ok_d = 1'b1;
          k_d        = '0;
          state_d    = DRAIN;
        end else begin
          frame_err_d = 1'b1;
          set_crc_err = 1'b1;
          state_d     = IDLE;
        end
      end

      DRAIN: begin
        out_valid_d = 1'b1;
        if (rx_done) begin
          set_overrun = 1'b1;
        end
        if (out_valid_q && out_ready) begin
          if (k_q == LAST_K) begin
            out_valid_d = 1'b0;
            k_d         = '0;
            state_d     = IDLE;
          end else begin
            k_d = k_q + IW'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sticky status: a new event in the same cycle as clr_status is kept
  always_comb begin
    status_d = clr_status ? 3'b000 : status_q;
    if (set_crc_err) status_d[0] = 1'b1;
    if (set_overrun) status_d[1] = 1'b1;
    if (set_timeout) status_d[2] = 1'b1;
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= IDLE;
      for (int i = 0; i < FRAME_LEN; i++) pay_q[i] <= 8'h00;
      idx_q       <= '0;
      k_q         <= '0;
      crc_q       <= 8'h00;
      shreg_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      rx_crc_q    <= 8'h00;
      out_valid_q <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      status_q    <= 3'b000;
    end else begin
      state_q     <= state_d;
      pay_q       <= pay_d;
      idx_q       <= idx_d;
      k_q         <= k_d;
      crc_q       <= crc_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_crc_q    <= rx_crc_d;
      out_valid_q <= out_valid_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      status_q    <= status_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_valid_q ? pay_q[k_q] : 8'h00;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);
  assign status    = status_q;

endmodule
